// File: rtl/alpide_word_packer.sv
// Packs ALPIDE link bytes MSB-first into 32-bit words with PAD-filled, evtdone-flagged event tails.
// Define ALPIDE_PACK_KEEP_BUSY_EN to pack BUSY_ON/OFF bytes as 1-byte items instead of dropping them.
module alpide_word_packer #(
  parameter logic [7:0]  PAD   = 8'hFF,
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reg_we_i,
  input  logic [7:0]  reg_addr_i,
  input  logic [15:0] reg_data_i,
  output logic [15:0] reg_data_o,
  input  logic [7:0]  byte_i,
  input  logic        byte_vld_i,
  output logic        byte_rdy_o,
  output logic        empty_o,
  output logic [31:0] data_o,
  output logic        evtdone_o,
  input  logic        re_i
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {CLS_DROP, CLS_PACK, CLS_ERR} cls_e;

  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    lane, rem, rem_nxt;
  logic [23:0]   partial;
  logic          in_event, efr, err;
  logic [15:0]   evcnt, errcnt;
  cls_e          cls;
  logic          eoe, set_evt, set_efr;
  logic          accept, push, pop, full, cmd_rst, cmd_clr, clr_all;
  logic [31:0]   word;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full       = (count == CW'(DEPTH));
  assign empty_o    = (count == '0);
  assign byte_rdy_o = (count < CW'(DEPTH));
  assign data_o     = empty_o ? '0 : mem[rd_ptr][31:0];
  assign evtdone_o  = !empty_o && mem[rd_ptr][32];

  assign cmd_rst = reg_we_i && (reg_addr_i == 8'h02) && (reg_data_i == 16'h0000);
  assign cmd_clr = reg_we_i && (reg_addr_i == 8'h02) && (reg_data_i == 16'h0002);
  assign clr_all = rst_i || cmd_rst;

  assign accept = byte_vld_i && byte_rdy_o;
  assign pop    = re_i && !empty_o;
  assign push   = accept && (cls == CLS_PACK) && ((lane == 2'd3) || eoe);

  always_comb begin
    cls     = CLS_DROP;
    rem_nxt = rem;
    eoe     = 1'b0;
    set_evt = 1'b0;
    set_efr = 1'b0;
    if (rem != 2'd0) begin
      cls     = CLS_PACK;
      rem_nxt = rem - 2'd1;
      eoe     = (rem == 2'd1) && efr;
    end else begin
      casez (byte_i)
        8'hFF: cls = CLS_DROP;
        8'hF0, 8'hF1: begin
`ifdef ALPIDE_PACK_KEEP_BUSY_EN
          cls = CLS_PACK;
`else
          cls = CLS_DROP;
`endif
        end
        8'b1010_????: begin cls = CLS_PACK; rem_nxt = 2'd1; set_evt = 1'b1; end
        8'b1110_????: begin cls = CLS_PACK; rem_nxt = 2'd1; set_evt = 1'b1; set_efr = 1'b1; end
        8'b1011_????: begin cls = CLS_PACK; eoe = 1'b1; end
        8'b110?_????: cls = CLS_PACK;
        8'b01??_????: begin cls = CLS_PACK; rem_nxt = 2'd1; end
        8'b00??_????: begin cls = CLS_PACK; rem_nxt = 2'd2; end
        default:      cls = CLS_ERR;
      endcase
    end
  end

  // Lanes above the current one take PAD; they only reach the FIFO on an end-of-event push.
  always_comb begin
    word[31:24] = (lane == 2'd0) ? byte_i : partial[23:16];
    word[23:16] = (lane == 2'd1) ? byte_i : (lane > 2'd1) ? partial[15:8] : PAD;
    word[15:8]  = (lane == 2'd2) ? byte_i : (lane == 2'd3) ? partial[7:0] : PAD;
    word[7:0]   = (lane == 2'd3) ? byte_i : PAD;
  end

  always_ff @(posedge clk_i) begin
    if (push && !clr_all) mem[wr_ptr] <= {eoe, word};
  end

  always_ff @(posedge clk_i) begin
    if (clr_all) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      lane     <= '0;
      rem      <= '0;
      partial  <= '0;
      in_event <= 1'b0;
      efr      <= 1'b0;
      err      <= 1'b0;
      evcnt    <= '0;
      errcnt   <= '0;
    end else begin
      if (accept && (cls == CLS_PACK)) begin
        rem  <= rem_nxt;
        lane <= eoe ? 2'd0 : lane + 2'd1;
        case (lane)
          2'd0:    partial[23:16] <= byte_i;
          2'd1:    partial[15:8]  <= byte_i;
          2'd2:    partial[7:0]   <= byte_i;
          default: ;
        endcase
        if (set_evt) in_event <= 1'b1;
        if (set_efr) efr <= 1'b1;
        if (eoe) begin
          in_event <= 1'b0;
          efr      <= 1'b0;
          evcnt    <= evcnt + 16'd1;
        end
      end
      if (accept && (cls == CLS_ERR)) begin
        err <= 1'b1;
        if (errcnt != '1) errcnt <= errcnt + 16'd1;
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (cmd_clr) begin
        err    <= 1'b0;
        evcnt  <= '0;
        errcnt <= '0;
      end
    end
  end

  always_comb begin
    case (reg_addr_i)
      8'h00:   reg_data_o = {8'b0, err, in_event, lane, rem, empty_o, full};
      8'h04:   reg_data_o = evcnt;
      8'h05:   reg_data_o = errcnt;
      default: reg_data_o = 16'hF001;
    endcase
  end

endmodule

// File: tb/tb_alpide_word_packer.sv
// Directed self-checking bench for alpide_word_packer; expected words are hand-computed from the byte streams.
module tb_alpide_word_packer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        reg_we_i;
  logic [7:0]  reg_addr_i;
  logic [15:0] reg_data_i;
  logic [15:0] reg_data_o;
  logic [7:0]  byte_i;
  logic        byte_vld_i;
  logic        byte_rdy_o;
  logic        empty_o;
  logic [31:0] data_o;
  logic        evtdone_o;
  logic        re_i;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  alpide_word_packer #(.PAD(8'hFF), .DEPTH(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i),
    .reg_data_i(reg_data_i), .reg_data_o(reg_data_o), .byte_i(byte_i),
    .byte_vld_i(byte_vld_i), .byte_rdy_o(byte_rdy_o), .empty_o(empty_o),
    .data_o(data_o), .evtdone_o(evtdone_o), .re_i(re_i)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_i     = b;
    byte_vld_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (byte_rdy_o) begin
        step();
        byte_vld_i = 1'b0;
        return;
      end
      step();
    end
    byte_vld_i = 1'b0;
    checks++;
    errors++;
    $display("FAIL send_byte_timeout: byte_rdy_o=%0b required 1", byte_rdy_o);
  endtask

  // Returns all-X on timeout so the caller's comparison fails.
  task automatic pop_word(output logic [32:0] w);
    for (int i = 0; i < 40; i++) begin
      if (!empty_o) begin
        w    = {evtdone_o, data_o};
        re_i = 1'b1;
        step();
        re_i = 1'b0;
        return;
      end
      step();
    end
    w = 'x;
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [15:0] v);
    reg_addr_i = a;
    #1;
    v = reg_data_o;
  endtask

  task automatic write_cmd(input logic [15:0] v);
    reg_we_i   = 1'b1;
    reg_addr_i = 8'h02;
    reg_data_i = v;
    step();
    reg_we_i   = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b want 1", empty_o); end
    checks++; if (evtdone_o !== 1'b0) begin errors++; $display("FAIL reset_evtdone: got %0b want 0", evtdone_o); end
    checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 00000000", data_o); end
    checks++; if (byte_rdy_o !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %0b want 1", byte_rdy_o); end
    read_reg(8'h00, v);
    checks++; if (v !== 16'h0002) begin errors++; $display("FAIL reset_status: got %h want 0002", v); end
    read_reg(8'h04, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_evcnt: got %h want 0000", v); end
    read_reg(8'h05, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_errcnt: got %h want 0000", v); end
    read_reg(8'h07, v);
    checks++; if (v !== 16'hF001) begin errors++; $display("FAIL unmapped_read: got %h want F001", v); end
  endtask

  task automatic test_event();
    logic [7:0]  s [6] = '{8'hA1, 8'h3C, 8'hC0, 8'h40, 8'h12, 8'hB0};
    logic [32:0] w;
    logic [15:0] v;
    foreach (s[i]) send_byte(s[i]);
    pop_word(w);
    checks++; if (w !== {1'b0, 32'hA13CC040}) begin errors++; $display("FAIL event_word0: got %h want 0a13cc040", w); end
    pop_word(w);
    checks++; if (w !== {1'b1, 32'h12B0FFFF}) begin errors++; $display("FAIL event_word1: got %h want 112b0ffff", w); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL event_empty_after: got %0b want 1", empty_o); end
    read_reg(8'h04, v);
    checks++; if (v !== 16'd1) begin errors++; $display("FAIL event_evcnt: got %0d want 1", v); end
    read_reg(8'h00, v);
    checks++; if (v !== 16'h0002) begin errors++; $display("FAIL event_status: got %h want 0002", v); end
  endtask

  task automatic test_empty_frame();
    logic [32:0] w;
    logic [15:0] v;
    send_byte(8'hE2);
    send_byte(8'h55);
    pop_word(w);
    checks++; if (w !== {1'b1, 32'hE255FFFF}) begin errors++; $display("FAIL empty_frame_word: got %h want 1e255ffff", w); end
    read_reg(8'h04, v);
    checks++; if (v !== 16'd2) begin errors++; $display("FAIL empty_frame_evcnt: got %0d want 2", v); end
  endtask

  task automatic test_idle_busy();
    logic [7:0]  s [9] = '{8'hFF, 8'hA0, 8'h07, 8'hF1, 8'hC3, 8'h00, 8'hFF, 8'h12, 8'hB0};
    logic [32:0] w, e0, e1;
`ifdef ALPIDE_PACK_KEEP_BUSY_EN
    e0 = {1'b0, 32'hA007F1C3};
    e1 = {1'b1, 32'h00FF12B0};
`else
    e0 = {1'b0, 32'hA007C300};
    e1 = {1'b1, 32'hFF12B0FF};
`endif
    foreach (s[i]) send_byte(s[i]);
    pop_word(w);
    checks++; if (w !== e0) begin errors++; $display("FAIL idle_busy_word0: got %h want %h", w, e0); end
    pop_word(w);
    checks++; if (w !== e1) begin errors++; $display("FAIL idle_busy_word1: got %h want %h", w, e1); end
  endtask

  task automatic test_back_pressure();
    logic [7:0]  s [12] = '{8'hA0, 8'h01, 8'hC0, 8'h40, 8'h41, 8'hC1,
                            8'h40, 8'h42, 8'hC2, 8'h40, 8'h43, 8'hB0};
    logic [32:0] exp [3] = '{{1'b0, 32'hA001C040}, {1'b0, 32'h41C14042}, {1'b1, 32'hC24043B0}};
    logic [32:0] got [3];
    logic [15:0] v;
    int idx = 0;
    int nw  = 0;
    re_i = 1'b0;
    for (int c = 0; c < 20 && idx < 12; c++) begin
      if (byte_rdy_o) begin
        byte_i = s[idx]; byte_vld_i = 1'b1; idx++;
      end else byte_vld_i = 1'b0;
      step();
    end
    byte_vld_i = 1'b0;
    checks++; if (idx !== 8) begin errors++; $display("FAIL bp_accepted_before_stall: got %0d want 8", idx); end
    checks++; if (byte_rdy_o !== 1'b0) begin errors++; $display("FAIL bp_rdy_low: got %0b want 0", byte_rdy_o); end
    checks++; if (data_o !== 32'hA001C040) begin errors++; $display("FAIL bp_head: got %h want a001c040", data_o); end
    re_i = 1'b1;
    for (int c = 0; c < 40 && nw < 3; c++) begin
      if (!empty_o) begin
        got[nw] = {evtdone_o, data_o}; nw++;
      end
      if (byte_rdy_o && idx < 12) begin
        byte_i = s[idx]; byte_vld_i = 1'b1; idx++;
      end else byte_vld_i = 1'b0;
      step();
    end
    re_i = 1'b0;
    byte_vld_i = 1'b0;
    checks++; if (nw !== 3) begin errors++; $display("FAIL bp_word_count: got %0d want 3", nw); end
    for (int i = 0; i < 3; i++) begin
      if (i < nw) begin
        checks++;
        if (got[i] !== exp[i]) begin errors++; $display("FAIL bp_word%0d: got %h want %h", i, got[i], exp[i]); end
      end
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL bp_drained: got %0b want 1", empty_o); end
    read_reg(8'h04, v);
    checks++; if (v !== 16'd4) begin errors++; $display("FAIL bp_evcnt: got %0d want 4", v); end
  endtask

  task automatic test_error();
    logic [15:0] v;
    send_byte(8'h85);
    read_reg(8'h05, v);
    checks++; if (v !== 16'd1) begin errors++; $display("FAIL err_errcnt: got %0d want 1", v); end
    read_reg(8'h00, v);
    checks++; if (v !== 16'h0082) begin errors++; $display("FAIL err_status: got %h want 0082", v); end
    write_cmd(16'h0002);
    read_reg(8'h05, v);
    checks++; if (v !== 16'd0) begin errors++; $display("FAIL clr_errcnt: got %0d want 0", v); end
    read_reg(8'h04, v);
    checks++; if (v !== 16'd0) begin errors++; $display("FAIL clr_evcnt: got %0d want 0", v); end
    read_reg(8'h00, v);
    checks++; if (v !== 16'h0002) begin errors++; $display("FAIL clr_status: got %h want 0002", v); end
  endtask

  task automatic test_cmd_rst();
    logic [15:0] v;
    logic [32:0] w;
    send_byte(8'hA1);
    send_byte(8'h3C);
    send_byte(8'hC0);
    read_reg(8'h00, v);
    checks++; if (v !== 16'h0072) begin errors++; $display("FAIL partial_status: got %h want 0072", v); end
    write_cmd(16'h0000);
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL cmdrst_empty: got %0b want 1", empty_o); end
    read_reg(8'h00, v);
    checks++; if (v !== 16'h0002) begin errors++; $display("FAIL cmdrst_status: got %h want 0002", v); end
    send_byte(8'hE2);
    send_byte(8'h55);
    pop_word(w);
    checks++; if (w !== {1'b1, 32'hE255FFFF}) begin errors++; $display("FAIL cmdrst_next_event: got %h want 1e255ffff", w); end
  endtask

  initial begin
    rst_i      = 1'b1;
    reg_we_i   = 1'b0;
    reg_addr_i = 8'h00;
    reg_data_i = 16'h0000;
    byte_i     = 8'h00;
    byte_vld_i = 1'b0;
    re_i       = 1'b0;
    test_reset();
    test_event();
    test_empty_frame();
    test_idle_busy();
    test_back_pressure();
    test_error();
    test_cmd_rst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
